// File: rtl/pin_accumulator.sv
// Per-channel windowed sums of din and ~din, handed off through a valid/ready output register.
// Optional PIN_ACC_SATURATE_EN makes every add clamp instead of wrapping.
module pin_accumulator #(
   parameter int CHANNELS  = 2,
   parameter int IN_WIDTH  = 20,
   parameter int ACC_WIDTH = 32,
   parameter int WINDOW    = 1024,
   localparam int WP_W     = $clog2(WINDOW)
) (
   input  logic                          sysclk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          signed_mode,
   input  logic [CHANNELS*IN_WIDTH-1:0]  din,
   output logic [CHANNELS*ACC_WIDTH-1:0] pos_sum,
   output logic [CHANNELS*ACC_WIDTH-1:0] neg_sum,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          overrun,
   output logic [WP_W-1:0]               window_pos
);

   logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_p_q, acc_p_d;
   logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_n_q, acc_n_d;
   logic [CHANNELS-1:0][ACC_WIDTH-1:0] sum_p, sum_n;
   logic [CHANNELS*ACC_WIDTH-1:0]      pos_sum_q, pos_sum_d;
   logic [CHANNELS*ACC_WIDTH-1:0]      neg_sum_q, neg_sum_d;
   logic                               out_valid_q, out_valid_d;
   logic                               overrun_q, overrun_d;
   logic [WP_W-1:0]                    window_pos_q, window_pos_d;
   logic                               win_end;
   logic                               load;

   function automatic logic [ACC_WIDTH-1:0] add_ext(
      input logic [ACC_WIDTH-1:0] acc,
      input logic [IN_WIDTH-1:0]  x,
      input logic                 sgn
   );
      logic [ACC_WIDTH-1:0] ext;
`ifdef PIN_ACC_SATURATE_EN
      logic [ACC_WIDTH:0]   wide;
`endif
      ext = ACC_WIDTH'(x);
      if (sgn && x[IN_WIDTH-1])
         ext = ext | ({ACC_WIDTH{1'b1}} << IN_WIDTH);
`ifdef PIN_ACC_SATURATE_EN
      wide = {1'b0, acc} + {1'b0, ext};
      if (!sgn)
         return wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
      // Signed overflow: like-signed operands producing a result of the other sign.
      if ((acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (wide[ACC_WIDTH-1] != acc[ACC_WIDTH-1]))
         return acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return wide[ACC_WIDTH-1:0];
`else
      return acc + ext;
`endif
   endfunction

   always_comb begin
      win_end = enable && (window_pos_q == WP_W'(WINDOW - 1));
      load    = win_end && (!out_valid_q || out_ready);

      for (int c = 0; c < CHANNELS; c++) begin
         sum_p[c] = add_ext(acc_p_q[c],  din[c*IN_WIDTH +: IN_WIDTH], signed_mode);
         sum_n[c] = add_ext(acc_n_q[c], ~din[c*IN_WIDTH +: IN_WIDTH], signed_mode);
      end

      acc_p_d      = acc_p_q;
      acc_n_d      = acc_n_q;
      window_pos_d = window_pos_q;
      pos_sum_d    = pos_sum_q;
      neg_sum_d    = neg_sum_q;
      out_valid_d  = out_valid_q;
      overrun_d    = overrun_q;

      if (enable) begin
         if (win_end) begin
            acc_p_d      = '0;
            acc_n_d      = '0;
            window_pos_d = '0;
         end else begin
            acc_p_d      = sum_p;
            acc_n_d      = sum_n;
            window_pos_d = window_pos_q + 1'b1;
         end
      end

      // The finished window includes this cycle's sample, so load the adder outputs directly.
      if (load) begin
         pos_sum_d   = sum_p;
         neg_sum_d   = sum_n;
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (win_end && out_valid_q && !out_ready)
         overrun_d = 1'b1;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         acc_p_q      <= '0;
         acc_n_q      <= '0;
         window_pos_q <= '0;
         pos_sum_q    <= '0;
         neg_sum_q    <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         acc_p_q      <= acc_p_d;
         acc_n_q      <= acc_n_d;
         window_pos_q <= window_pos_d;
         pos_sum_q    <= pos_sum_d;
         neg_sum_q    <= neg_sum_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign pos_sum    = pos_sum_q;
   assign neg_sum    = neg_sum_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;
   assign window_pos = window_pos_q;

endmodule
